// File: rtl/clk_timer_pkg.sv
// Shared types and defaults for the clk_down_timer slice.
package clk_timer_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } timer_state_t;

endpackage

// File: rtl/clk_down_timer_if.sv
// Load/status bundle between a timer owner (master) and clk_down_timer (slave).
interface clk_down_timer_if #(
    parameter int unsigned WIDTH = clk_timer_pkg::DEFAULT_WIDTH
);
    logic             clr;
    logic             enable;
    logic             load_valid;
    logic [WIDTH-1:0] load_val;
    logic             load_ready;
    logic [WIDTH-1:0] out;
    logic             busy;
    logic             done;

    modport master (
        output clr, enable, load_valid, load_val,
        input  load_ready, out, busy, done
    );

    modport slave (
        input  clr, enable, load_valid, load_val,
        output load_ready, out, busy, done
    );
endinterface

// File: rtl/clk_down_timer.sv
// Loadable down-counter with a registered one-cycle done pulse on expiry.
// Optional periodic reload enabled by defining CLK_DOWN_TIMER_RELOAD_EN.
module clk_down_timer
    import clk_timer_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic              clk,
    input  logic              reset,
`ifdef CLK_DOWN_TIMER_RELOAD_EN
    input  logic              auto_reload,
`endif
    clk_down_timer_if.slave   bus
);

    timer_state_t     state_q, state_d;
    logic [WIDTH-1:0] cnt_q,   cnt_d;
    logic             done_q,  done_d;
    logic             reload_hit;

`ifdef CLK_DOWN_TIMER_RELOAD_EN
    logic [WIDTH-1:0] reload_q, reload_d;
    assign reload_hit = auto_reload;
`else
    assign reload_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
`ifdef CLK_DOWN_TIMER_RELOAD_EN
        reload_d = reload_q;
`endif
        if (bus.clr) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.load_valid) begin
                        cnt_d = bus.load_val;
`ifdef CLK_DOWN_TIMER_RELOAD_EN
                        reload_d = bus.load_val;
`endif
                        // A zero load expires immediately without entering RUN.
                        if (bus.load_val == '0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = RUN;
                        end
                    end
                end
                RUN: begin
                    if (bus.enable) begin
                        if (cnt_q > WIDTH'(1)) begin
                            cnt_d = cnt_q - WIDTH'(1);
                        end else begin
                            done_d = 1'b1;
                            if (reload_hit) begin
`ifdef CLK_DOWN_TIMER_RELOAD_EN
                                cnt_d = reload_q;
`endif
                            end else begin
                                cnt_d   = '0;
                                state_d = IDLE;
                            end
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

`ifdef CLK_DOWN_TIMER_RELOAD_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reload_q <= '0;
        end else begin
            reload_q <= reload_d;
        end
    end
`endif

    assign bus.load_ready = (state_q == IDLE) & ~bus.clr;
    assign bus.busy       = (state_q == RUN);
    assign bus.out        = cnt_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_clk_down_timer.sv
// Randomised and directed bench for clk_down_timer against a behavioural model.
module tb_clk_down_timer;

    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic auto_reload = 1'b0;

    int total = 0;
    int bad   = 0;

    clk_down_timer_if #(.WIDTH(W)) bus();

    clk_down_timer #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
`ifdef CLK_DOWN_TIMER_RELOAD_EN
        .auto_reload (auto_reload),
`endif
        .bus         (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: running flag plus integer count and captured period.
    bit m_run    = 0;
    int m_out    = 0;
    int m_reload = 0;
    bit m_done   = 0;
    bit reload_on;

`ifdef CLK_DOWN_TIMER_RELOAD_EN
    assign reload_on = auto_reload;
`else
    assign reload_on = 1'b0;
`endif

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_run = 0; m_out = 0; m_reload = 0; m_done = 0;
        end else begin
            m_done = 0;
            if (bus.clr) begin
                m_run = 0; m_out = 0;
            end else if (!m_run) begin
                if (bus.load_valid) begin
                    m_out    = int'(bus.load_val);
                    m_reload = m_out;
                    if (m_out == 0) m_done = 1;
                    else            m_run  = 1;
                end
            end else if (bus.enable) begin
                if (m_out == 1) begin
                    m_done = 1;
                    if (reload_on) m_out = m_reload;
                    else begin m_out = 0; m_run = 0; end
                end else begin
                    m_out = m_out - 1;
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("model_out",   int'(bus.out),        m_out);
        check("model_busy",  int'(bus.busy),       int'(m_run));
        check("model_done",  int'(bus.done),       int'(m_done));
        check("model_ready", int'(bus.load_ready), int'(!m_run && !bus.clr));
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        bus.clr = 0; bus.enable = 0; bus.load_valid = 0; bus.load_val = '0;
    endtask

    task automatic load(input int v);
        bus.load_valid = 1;
        bus.load_val   = W'(v);
        cyc();
        bus.load_valid = 0;
    endtask

    initial begin
        int exp_seq[6];
        int en_seq[6];
        int n;
        int done_cnt;
        idle_inputs();

        // 1: reset held for three cycles
        repeat (3) cyc();
        reset = 1;
        cyc();
        check("rst_out",   int'(bus.out), 0);
        check("rst_done",  int'(bus.done), 0);
        check("rst_busy",  int'(bus.busy), 0);
        check("rst_ready", int'(bus.load_ready), 1);

        // 2: load 5 with enable held
        bus.enable = 1;
        load(5);
        check("l5_out0", int'(bus.out), 5);
        check("l5_busy", int'(bus.busy), 1);
        exp_seq = '{4, 3, 2, 1, 0, 0};
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("l5_seq",  int'(bus.out), exp_seq[i]);
            check("l5_done", int'(bus.done), (exp_seq[i] == 0) ? 1 : 0);
        end
        check("l5_end_busy",  int'(bus.busy), 0);
        check("l5_end_ready", int'(bus.load_ready), 1);
        cyc();
        check("l5_done_drop", int'(bus.done), 0);

        // 3: load 4 with gated enable; loads while busy are ignored
        bus.enable = 0;
        load(4);
        check("l4_out0", int'(bus.out), 4);
        exp_seq = '{3, 3, 2, 1, 1, 0};
        en_seq  = '{1, 0, 1, 1, 0, 1};
        done_cnt = 0;
        bus.load_valid = 1;
        bus.load_val   = 8'd9;
        for (int i = 0; i < 6; i++) begin
            bus.enable = en_seq[i][0];
            cyc();
            check("l4_seq", int'(bus.out), exp_seq[i]);
            done_cnt += int'(bus.done);
        end
        bus.load_valid = 0;
        bus.enable = 0;
        check("l4_done_once", done_cnt, 1);

        // 4: zero load expires at once; full-scale load counts all the way
        load(0);
        check("l0_done", int'(bus.done), 1);
        check("l0_busy", int'(bus.busy), 0);
        check("l0_out",  int'(bus.out), 0);
        bus.enable = 1;
        load(255);
        check("l255_out0", int'(bus.out), 255);
        n = 0;
        while (!bus.done && n < 300) begin
            cyc();
            n++;
        end
        check("l255_edges", n, 255);

        // 5: synchronous clear mid-count
        load(10);
        repeat (3) cyc();
        check("clr_pre", int'(bus.out), 7);
        bus.clr = 1;
        #1 check("clr_ready_comb", int'(bus.load_ready), 0);
        cyc();
        bus.clr = 0;
        check("clr_out",  int'(bus.out), 0);
        check("clr_busy", int'(bus.busy), 0);
        check("clr_done", int'(bus.done), 0);

        // 5b: asynchronous reset mid-count
        load(10);
        repeat (3) cyc();
        check("arst_pre", int'(bus.out), 7);
        reset = 0;
        #1;
        check("arst_out",  int'(bus.out), 0);
        check("arst_busy", int'(bus.busy), 0);
        check("arst_done", int'(bus.done), 0);
        cyc();
        reset = 1;
        cyc();

`ifdef CLK_DOWN_TIMER_RELOAD_EN
        // 6: periodic reload, then drop auto_reload
        auto_reload = 1;
        bus.enable = 1;
        load(3);
        exp_seq = '{2, 1, 3, 2, 1, 3};
        for (int i = 0; i < 6; i++) begin
            cyc();
            check("rl_seq",  int'(bus.out), exp_seq[i]);
            check("rl_done", int'(bus.done), (exp_seq[i] == 3) ? 1 : 0);
            check("rl_busy", int'(bus.busy), 1);
        end
        auto_reload = 0;
        repeat (3) cyc();
        check("rl_stop_out",  int'(bus.out), 0);
        check("rl_stop_busy", int'(bus.busy), 0);
        check("rl_stop_done", int'(bus.done), 1);
        cyc();
`endif

        // Random phase, checked by the model each cycle
        for (int c = 0; c < 3000; c++) begin
            bus.clr        = ($urandom_range(0, 49) == 0);
            bus.enable     = ($urandom_range(0, 3) != 0);
            bus.load_valid = ($urandom_range(0, 2) == 0);
            bus.load_val   = ($urandom_range(0, 9) == 0) ? W'($urandom) : W'($urandom_range(0, 12));
            auto_reload    = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 199) == 0) begin
                reset = 0;
                cyc();
                reset = 1;
            end else begin
                cyc();
            end
        end
        idle_inputs();
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
